// File: rtl/dram_cmd_scheduler.sv
// DRAM command scheduler: open-page row table per bank, issues PRE/ACT/RD/WR
// with tRP/tRCD/tCL spacing and pulses a one-cycle completion response.
module dram_cmd_scheduler #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RP         = 2,
  parameter int T_RCD        = 2,
  parameter int T_CL         = 2,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [BW-1:0]           req_bank_id,
  input  logic [RW-1:0]           req_row_id,
  input  logic [CW-1:0]           req_col_id,
  output logic                    cmd_valid,
  output logic [2:0]              cmd_op,
  output logic [BW-1:0]           cmd_bank,
  output logic [RW-1:0]           cmd_row,
  output logic [CW-1:0]           cmd_col,
  output logic                    resp_valid,
  output logic                    resp_we,
  output logic                    resp_row_hit,
  output logic [NUM_OF_BANKS-1:0] open_bank_mask
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_WAIT_RP, ST_ACT, ST_WAIT_RCD, ST_CAS, ST_WAIT_CL, ST_DONE
  } state_t;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] bank;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          hit;
  } req_t;

  state_t                         state, state_nxt;
  req_t                           lat, cur;
  logic [NUM_OF_BANKS-1:0]        tbl_vld;
  logic [NUM_OF_BANKS-1:0][RW-1:0] tbl_row;
  logic [3:0]                     cnt, cnt_nxt;
  logic                           accept;

  logic          cmd_valid_nxt, resp_valid_nxt, resp_we_nxt, resp_hit_nxt;
  logic [2:0]    cmd_op_nxt;
  logic [BW-1:0] cmd_bank_nxt;
  logic [RW-1:0] cmd_row_nxt;
  logic [CW-1:0] cmd_col_nxt;

  assign req_ready      = (state == ST_IDLE);
  assign accept         = req_valid && req_ready;
  assign open_bank_mask = tbl_vld;

  // On the accept cycle the live request is used directly so outputs can be
  // registered from the next state without a bubble.
  always_comb begin
    cur = lat;
    if (accept) begin
      cur.we   = req_we;
      cur.bank = req_bank_id;
      cur.row  = req_row_id;
      cur.col  = req_col_id;
      cur.hit  = tbl_vld[req_bank_id] && (tbl_row[req_bank_id] == req_row_id);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (cur.hit)                   state_nxt = ST_CAS;
          else if (tbl_vld[req_bank_id]) state_nxt = ST_PRE;
          else                           state_nxt = ST_ACT;
        end
      end
      ST_PRE:      state_nxt = ST_WAIT_RP;
      ST_WAIT_RP:  if (cnt == 4'd0) state_nxt = ST_ACT;
      ST_ACT:      state_nxt = ST_WAIT_RCD;
      ST_WAIT_RCD: if (cnt == 4'd0) state_nxt = ST_CAS;
      ST_CAS:      state_nxt = ST_WAIT_CL;
      ST_WAIT_CL:  if (cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Counter is loaded with T_x-1 on entry, so a WAIT_x state lasts T_x cycles.
  always_comb begin
    cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    if (state_nxt == ST_WAIT_RP  && state != ST_WAIT_RP)  cnt_nxt = 4'(T_RP - 1);
    if (state_nxt == ST_WAIT_RCD && state != ST_WAIT_RCD) cnt_nxt = 4'(T_RCD - 1);
    if (state_nxt == ST_WAIT_CL  && state != ST_WAIT_CL)  cnt_nxt = 4'(T_CL - 1);
  end

  always_comb begin
    cmd_op_nxt     = OP_NOP;
    cmd_bank_nxt   = '0;
    cmd_row_nxt    = '0;
    cmd_col_nxt    = '0;
    resp_valid_nxt = 1'b0;
    resp_we_nxt    = 1'b0;
    resp_hit_nxt   = 1'b0;
    case (state_nxt)
      ST_PRE: begin
        // Table still holds the row being closed when PRE is scheduled.
        cmd_op_nxt   = OP_PRE;
        cmd_bank_nxt = cur.bank;
        cmd_row_nxt  = tbl_row[cur.bank];
      end
      ST_ACT: begin
        cmd_op_nxt   = OP_ACT;
        cmd_bank_nxt = cur.bank;
        cmd_row_nxt  = cur.row;
      end
      ST_CAS: begin
        cmd_op_nxt   = cur.we ? OP_WR : OP_RD;
        cmd_bank_nxt = cur.bank;
        cmd_row_nxt  = cur.row;
        cmd_col_nxt  = cur.col;
      end
      ST_DONE: begin
        resp_valid_nxt = 1'b1;
        resp_we_nxt    = cur.we;
        resp_hit_nxt   = cur.hit;
      end
      default: ;
    endcase
    cmd_valid_nxt = (cmd_op_nxt != OP_NOP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lat          <= '0;
      tbl_vld      <= '0;
      tbl_row      <= '0;
      cnt          <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= OP_NOP;
      cmd_bank     <= '0;
      cmd_row      <= '0;
      cmd_col      <= '0;
      resp_valid   <= 1'b0;
      resp_we      <= 1'b0;
      resp_row_hit <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) lat <= cur;
      if (state == ST_PRE) tbl_vld[lat.bank] <= 1'b0;
      if (state == ST_ACT) begin
        tbl_vld[lat.bank] <= 1'b1;
        tbl_row[lat.bank] <= lat.row;
      end
      cmd_valid    <= cmd_valid_nxt;
      cmd_op       <= cmd_op_nxt;
      cmd_bank     <= cmd_bank_nxt;
      cmd_row      <= cmd_row_nxt;
      cmd_col      <= cmd_col_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_we      <= resp_we_nxt;
      resp_row_hit <= resp_hit_nxt;
    end
  end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sits directly downstream of the address decoder. Consumes one decoded request at a time (bank_id, row_id, col_id plus a read/write flag).
- Keeps an open-row table with one entry per bank, using an open-page policy.
- Issues the required DRAM command sequence (PRE, ACT, RD/WR) and enforces the tRP, tRCD and tCL spacing between commands.
- Pulses a one-cycle completion response to the upstream controller FSM.

Parameters:
- NUM_OF_BANKS, 8, number of banks; BW = $clog2(NUM_OF_BANKS)
- NUM_OF_ROWS, 128, rows per bank; RW = $clog2(NUM_OF_ROWS)
- NUM_OF_COLS, 8, columns per row; CW = $clog2(NUM_OF_COLS)
- T_RP, 2, NOP cycles after PRE before ACT (legal range 1..15)
- T_RCD, 2, NOP cycles after ACT before RD/WR (legal range 1..15)
- T_CL, 2, NOP cycles after RD/WR before resp_valid (legal range 1..15)

Ports:
- clk  input  1  single clock, all logic on the rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  decoded request present
- req_ready  output  1  scheduler can accept a request
- req_we  input  1  1 = write, 0 = read
- req_bank_id  input  BW  bank from the decoder
- req_row_id  input  RW  row from the decoder
- req_col_id  input  CW  column from the decoder
- cmd_valid  output  1  a command is driven this cycle
- cmd_op  output  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE
- cmd_bank  output  BW  command bank
- cmd_row  output  RW  command row
- cmd_col  output  CW  command column
- resp_valid  output  1  one-cycle completion pulse
- resp_we  output  1  write flag of the completed request
- resp_row_hit  output  1  completed request was a row hit
- open_bank_mask  output  NUM_OF_BANKS  bit b = bank b has an open row

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state, applied at the next clk edge with rst_n=0, including mid-sequence:
  - FSM goes to IDLE and the open-row table is cleared.
  - req_ready=1.
  - cmd_valid=0, cmd_op=0, cmd_bank=0, cmd_row=0, cmd_col=0.
  - resp_valid=0, resp_we=0, resp_row_hit=0, open_bank_mask=0.
  - An interrupted request is dropped and produces no resp_valid.
- Registered outputs: all outputs are registered except req_ready, which is high exactly when the state is IDLE.
- Accept: happens when req_valid && req_ready. The request fields are captured in that cycle only and are not sampled afterwards.
- Row classification against the table entry for req_bank_id, made on the same accept edge:
  - Hit (entry open, same row): next state CAS.
  - Empty (entry closed): next state ACT.
  - Conflict (entry open, different row): next state PRE.
- FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CL, DONE.
- PRE: one cycle.
  - Drives cmd_op=4, cmd_bank = latched bank, cmd_row = row being closed, cmd_col=0.
  - Clears the table entry.
  - Then exactly T_RP cycles in WAIT_RP, then ACT.
- ACT: one cycle.
  - Drives cmd_op=1 with the latched bank and row, cmd_col=0.
  - Sets the table entry open with the latched row.
  - Then exactly T_RCD cycles in WAIT_RCD, then CAS.
- CAS: one cycle.
  - Drives cmd_op = 3 for a write, 2 for a read, with the latched bank, row and column.
  - Then exactly T_CL cycles in WAIT_CL, then DONE.
- DONE: one cycle.
  - Drives resp_valid=1, resp_we, and resp_row_hit (1 only if the request was classified as a hit at accept).
  - The next state is IDLE.
- Output values outside command cycles:
  - In every non-command cycle, cmd_valid=0 and cmd_op, cmd_bank, cmd_row, cmd_col are all 0.
  - resp_valid=0 outside DONE.
- Wait counters: 4-bit down-counters loaded with T_x-1 on entry to a WAIT_x state. The WAIT_x state exits when the counter reads 0.
- Latency, for accept at cycle N:
  - Hit: CAS at N+1, resp_valid at N+2+T_CL.
  - Empty: ACT at N+1, CAS at N+2+T_RCD, resp_valid at N+3+T_RCD+T_CL.
  - Conflict: PRE at N+1, ACT at N+2+T_RP, CAS at N+3+T_RP+T_RCD, resp_valid at N+4+T_RP+T_RCD+T_CL.
- Back-to-back requests: req_ready rises in the cycle after DONE (state IDLE). A request held valid through DONE is accepted on the first IDLE cycle.
- Row state persistence: rows stay open indefinitely. Only a conflict on the same bank, or reset, closes a row. Other banks' entries are never touched.
- open_bank_mask: reflects the table, updated on the PRE and ACT edges.
- Back-pressure: req_valid while not IDLE has no effect.
- Parameter range: T_x values outside 1..15 are illegal configurations.

Test Plan:
- Reset, then read bank 2 row 5 col 3 accepted at cycle 0 (defaults) -> ACT(b2,r5) at cycle 1, RD(b2,r5,c3) at cycle 4, resp_valid at cycle 7 with resp_row_hit=0; open_bank_mask=8'h04 from cycle 2.
- Write bank 2 row 5 col 1 accepted at cycle 0 (bank 2 row 5 already open) -> WR at cycle 1, resp_valid at cycle 4 with resp_we=1, resp_row_hit=1, no ACT/PRE.
- Read bank 2 row 9 accepted at cycle 0 (bank 2 row 5 open) -> PRE(b2,r5) at 1, ACT(b2,r9) at 4, RD at 7, resp at 10; open_bank_mask bit 2 drops at cycle 2 and rises again at cycle 5.
- Open rows in banks 0 and 7, then hit bank 7 -> open_bank_mask=8'h81 throughout, hit latency 4 cycles, bank 0 entry unchanged.
- rst_n=0 for one cycle during WAIT_RCD -> next cycle IDLE, req_ready=1, open_bank_mask=0, no RD/WR and no resp_valid ever issued for that request.
- req_valid held high continuously with T_RP=T_RCD=T_CL=1 -> each accept occurs exactly one cycle after the previous resp_valid; cmd_valid is never asserted in two consecutive cycles.
